// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single-port synchronous memory with 1-cycle read latency.
// CPU (m0) has default priority; a starvation counter and a burst lock keep m1 moving.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [7:0]    starve_cnt
);

  localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

  logic owner_lock;
  logic rd_pending;
  logic rd_owner;
  logic grant_m0;
  logic grant_m1;
  logic rd_grant;

  // Grant decision; everything is forced quiet while reset is asserted.
  always_comb begin
    grant_m0 = 1'b0;
    grant_m1 = 1'b0;
    if (rst) begin
      if (owner_lock && m1_req) begin
        grant_m1 = 1'b1;
      end else if (m1_req && (starve_cnt >= STARVE_LIM8)) begin
        grant_m1 = 1'b1;
      end else if (m0_req) begin
        grant_m0 = 1'b1;
      end else if (m1_req) begin
        grant_m1 = 1'b1;
      end
    end
  end

  assign m0_gnt   = grant_m0;
  assign m1_gnt   = grant_m1;
  assign rd_grant = (grant_m0 && !m0_we) || (grant_m1 && !m1_we);

  // With no grant the CPU address stays on the bus so fetch timing is unaffected.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (rst) begin
      if (grant_m1) begin
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_we    = m1_we;
      end else if (grant_m0) begin
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_we    = m0_we;
      end else begin
        mem_addr  = m0_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_lock <= 1'b0;
      starve_cnt <= 8'd0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (!m1_req || !m1_lock) begin
        owner_lock <= 1'b0;
      end else if (grant_m1) begin
        owner_lock <= 1'b1;
      end

      if (grant_m1 || !m1_req) begin
        starve_cnt <= 8'd0;
      end else if (starve_cnt != 8'hFF) begin
        starve_cnt <= starve_cnt + 8'd1;
      end

      rd_pending <= rd_grant;
      if (rd_grant) begin
        rd_owner <= grant_m1;
      end
    end
  end

  // Read data follows the address by one cycle; steer it to whoever issued the read.
  assign m0_rvalid = rst && rd_pending && !rd_owner;
  assign m1_rvalid = rst && rd_pending && rd_owner;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle grant/bus checks plus a read-return scoreboard.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [7:0]  starve_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit          owner;
    logic [31:0] data;
    int          cyc;
  } rd_exp_t;
  rd_exp_t sb[$];

  logic [31:0] mem [logic [31:0]];

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port memory with 1-cycle read latency
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] = mem_wdata;
    mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : ~mem_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_m0(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input bit r, input bit w, input bit l, input logic [31:0] a,
                        input logic [31:0] d);
    m1_req = r; m1_we = w; m1_lock = l; m1_addr = a; m1_wdata = d;
  endtask

  task automatic idle();
    set_m0(0, 0, 32'h0, 32'h0);
    set_m1(0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic expect_rd(input bit owner, input logic [31:0] data);
    rd_exp_t e;
    e.owner = owner; e.data = data; e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic cyc_chk(input string name, input bit g0, input bit g1, input bit we,
                         input logic [31:0] addr, input logic [31:0] wd, input int cnt);
    @(negedge clk);
    chk({name, ".m0_gnt"},     32'(m0_gnt),     32'(g0));
    chk({name, ".m1_gnt"},     32'(m1_gnt),     32'(g1));
    chk({name, ".mem_we"},     32'(mem_we),     32'(we));
    chk({name, ".mem_addr"},   mem_addr,        addr);
    chk({name, ".mem_wdata"},  mem_wdata,       wd);
    chk({name, ".starve_cnt"}, 32'(starve_cnt), 32'(cnt));
    @(posedge clk);
    #1;
  endtask

  // Read-return monitor
  always @(negedge clk) begin
    rd_exp_t e;
    if (m0_rvalid && m1_rvalid) begin
      checks++; failures++;
      $display("FAIL rvalid_both: got m0=1 m1=1 want at most one (cycle %0d)", cyc);
    end
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++; failures++;
      $display("FAIL rd_missing: got no rvalid want owner m%0d data 0x%0h at cycle %0d",
               e.owner, e.data, e.cyc);
    end
    if (m0_rvalid || m1_rvalid) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected: got rvalid m0=%0b m1=%0b want none (cycle %0d)",
                 m0_rvalid, m1_rvalid, cyc);
      end else begin
        e = sb.pop_front();
        chk("rd_owner", 32'(m1_rvalid), 32'(e.owner));
        chk("rd_data", m1_rvalid ? m1_rdata : m0_rdata, e.data);
        chk("rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h10] = 32'hDEADBEEF;
    mem[32'h4]  = 32'h11111111;
    mem[32'h8]  = 32'h22222222;
    mem[32'hC]  = 32'h33333333;

    // Reset: outputs quiet even with a live request
    rst = 1'b0;
    idle();
    set_m0(1, 1, 32'h55, 32'h66);
    set_m1(1, 0, 1, 32'h77, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    cyc_chk("reset", 0, 0, 0, 32'h0, 32'h0, 0);
    idle();
    rst = 1'b1;
    cyc_chk("idle0", 0, 0, 0, 32'h0, 32'h0, 0);

    // Single m0 read
    set_m0(1, 0, 32'h10, 32'h0);
    expect_rd(0, 32'hDEADBEEF);
    cyc_chk("m0_rd", 1, 0, 0, 32'h10, 32'h0, 0);
    idle();
    cyc_chk("m0_rd_after", 0, 0, 0, 32'h0, 32'h0, 0);

    // Starvation forcing with both requesting writes
    set_m0(1, 1, 32'h100, 32'hA0);
    set_m1(1, 1, 0, 32'h200, 32'hB0);
    for (int i = 0; i < 8; i++) cyc_chk("starve_m0", 1, 0, 1, 32'h100, 32'hA0, i);
    cyc_chk("starve_m1", 0, 1, 1, 32'h200, 32'hB0, 8);
    cyc_chk("starve_regrant", 1, 0, 1, 32'h100, 32'hA0, 0);
    idle();
    cyc_chk("starve_idle1", 0, 0, 0, 32'h0, 32'h0, 1);
    cyc_chk("starve_idle2", 0, 0, 0, 32'h0, 32'h0, 0);

    // Locked m1 write burst of 4 while m0 keeps requesting
    set_m0(1, 1, 32'h300, 32'hC0);
    set_m1(1, 1, 1, 32'h400, 32'hD0);
    for (int i = 0; i < 8; i++) cyc_chk("burst_pre", 1, 0, 1, 32'h300, 32'hC0, i);
    for (int b = 0; b < 4; b++) begin
      set_m1(1, 1, 1, 32'h400 + 32'(4 * b), 32'hD0 + 32'(b));
      cyc_chk("burst", 0, 1, 1, 32'h400 + 32'(4 * b), 32'hD0 + 32'(b), (b == 0) ? 8 : 0);
    end
    set_m1(0, 0, 0, 32'h0, 32'h0);
    cyc_chk("burst_post", 1, 0, 1, 32'h300, 32'hC0, 0);
    idle();
    cyc_chk("burst_idle", 0, 0, 0, 32'h0, 32'h0, 0);

    // Alternating reads m0@4, m1@8 (via starvation), m0@C
    set_m0(1, 1, 32'h500, 32'h50);
    set_m1(1, 0, 0, 32'h8, 32'h0);
    for (int i = 0; i < 7; i++) cyc_chk("alt_pre", 1, 0, 1, 32'h500, 32'h50, i);
    set_m0(1, 0, 32'h4, 32'h0);
    expect_rd(0, 32'h11111111);
    cyc_chk("alt_m0a", 1, 0, 0, 32'h4, 32'h0, 7);
    set_m0(1, 0, 32'hC, 32'h0);
    expect_rd(1, 32'h22222222);
    cyc_chk("alt_m1", 0, 1, 0, 32'h8, 32'h0, 8);
    set_m1(0, 0, 0, 32'h0, 32'h0);
    expect_rd(0, 32'h33333333);
    cyc_chk("alt_m0c", 1, 0, 0, 32'hC, 32'h0, 0);
    idle();
    cyc_chk("alt_idle1", 0, 0, 0, 32'h0, 32'h0, 0);
    cyc_chk("alt_idle2", 0, 0, 0, 32'h0, 32'h0, 0);

    // Reset the cycle after an m1 read grant: its rvalid must never appear
    set_m1(1, 0, 0, 32'h8, 32'h0);
    cyc_chk("rst_m1rd", 0, 1, 0, 32'h8, 32'h0, 0);
    rst = 1'b0;
    set_m0(1, 0, 32'h10, 32'h0);
    #3;
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
    cyc_chk("in_rst1", 0, 0, 0, 32'h0, 32'h0, 0);
    cyc_chk("in_rst2", 0, 0, 0, 32'h0, 32'h0, 0);
    rst = 1'b1;
    set_m1(0, 0, 0, 32'h0, 32'h0);
    expect_rd(0, 32'hDEADBEEF);
    cyc_chk("post_rst_rd", 1, 0, 0, 32'h10, 32'h0, 0);
    idle();
    cyc_chk("post_rst_idle", 0, 0, 0, 32'h0, 32'h0, 0);

    // m0 write, then read it back through the memory
    set_m0(1, 1, 32'h20, 32'h1234);
    cyc_chk("m0_wr", 1, 0, 1, 32'h20, 32'h1234, 0);
    idle();
    cyc_chk("m0_wr_idle1", 0, 0, 0, 32'h0, 32'h0, 0);
    cyc_chk("m0_wr_idle2", 0, 0, 0, 32'h0, 32'h0, 0);
    set_m0(1, 0, 32'h20, 32'h0);
    expect_rd(0, 32'h1234);
    cyc_chk("m0_rdback", 1, 0, 0, 32'h20, 32'h0, 0);
    idle();
    cyc_chk("drain1", 0, 0, 0, 32'h0, 32'h0, 0);
    cyc_chk("drain2", 0, 0, 0, 32'h0, 32'h0, 0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous memory unit between two masters:
  - Master 0: the CPU fetch/data path.
  - Master 1: a secondary master, such as the program loader or DMA engine.
- Decides one owner per cycle, muxes address, write data and write enable onto the memory port, and steers the 1-cycle-latency read data back to the owner with a valid strobe.
- Default priority goes to the CPU. A starvation counter and a burst lock guarantee master 1 progress.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 8, consecutive cycles master 1 may be denied before it is forced priority (range 1-255)

Ports:
- clk, input, 1, system clock
- rst, input, 1, asynchronous, active-low reset
- m0_req, input, 1, master 0 transaction request
- m0_we, input, 1, master 0 write (1) / read (0)
- m0_addr, input, AW, master 0 address
- m0_wdata, input, DW, master 0 write data
- m0_gnt, output, 1, master 0 transaction accepted this cycle
- m0_rvalid, output, 1, master 0 read data valid
- m0_rdata, output, DW, master 0 read data
- m1_req, input, 1, master 1 transaction request
- m1_we, input, 1, master 1 write / read
- m1_lock, input, 1, master 1 burst lock, keep ownership
- m1_addr, input, AW, master 1 address
- m1_wdata, input, DW, master 1 write data
- m1_gnt, output, 1, master 1 transaction accepted this cycle
- m1_rvalid, output, 1, master 1 read data valid
- m1_rdata, output, DW, master 1 read data
- mem_addr, output, AW, memory address
- mem_wdata, output, DW, memory write data
- mem_we, output, 1, memory write enable
- mem_rdata, input, DW, memory read data, valid the cycle after the address
- starve_cnt, output, 8, current master 1 denial count (debug)

Behaviour:
- Reset (rst low, asynchronous):
  - Registered state cleared: owner_lock=0, starve_cnt=0, rd_pending=0, rd_owner=0.
  - m0_gnt, m1_gnt, mem_we, m0_rvalid and m1_rvalid are all 0 while rst is low.
  - mem_addr and mem_wdata are 0 while rst is low.
- Handshake:
  - A master holds req, we, addr and wdata stable until it samples gnt=1 at a rising edge.
  - gnt is combinational from the current-cycle requests and registered arbiter state.
  - A transaction is complete on the edge where gnt=1.
  - Exactly one of m0_gnt/m1_gnt may be high in a cycle. Both may be low.
- Grant decision, evaluated each cycle in this order:
  1. If owner_lock=1 and m1_req=1: grant m1.
  2. Else if m1_req=1 and starve_cnt >= STARVE_LIMIT: grant m1.
  3. Else if m0_req=1: grant m0.
  4. Else if m1_req=1: grant m1.
  5. Else: no grant.
- Memory port drive:
  - Drive mem_addr, mem_wdata and mem_we from the granted master.
  - mem_we = granted master's we, and is 0 when there is no grant.
  - With no grant, mem_addr holds m0_addr so the CPU fetch address stays visible; mem_wdata is 0.
- owner_lock:
  - Set at an edge where m1_gnt=1 and m1_lock=1.
  - Cleared at an edge where m1_lock=0 or m1_req=0.
  - While owner_lock is set, m0 is starved deliberately; this is the loader's responsibility.
- starve_cnt:
  - Increments (saturating at 255) on an edge where m1_req=1 and m1_gnt=0.
  - Clears on an edge where m1_gnt=1 or m1_req=0.
- Read return:
  - On an edge where a read is granted (gnt=1, we=0): rd_pending=1 and rd_owner=granted master.
  - Next cycle, {rd_owner}_rvalid=1 and its rdata equals mem_rdata. The other master's rvalid is 0.
  - rd_pending clears unless another read is granted on the same edge.
  - Back-to-back reads give one read per cycle with 1-cycle latency, in grant order.
  - m*_rdata outputs pass mem_rdata through, qualified only by rvalid.
- Writes: no rvalid is generated. A write is complete at the grant edge.
- Simultaneous requests with starve_cnt < STARVE_LIMIT and no lock: m0 wins and starve_cnt increments.
- Reset mid-read: the pending rvalid is dropped and never asserted after reset release.

Test Plan:
- Only m0 reads addr 0x10 with mem_rdata=0xDEADBEEF next cycle -> m0_gnt=1 in cycle 0; m0_rvalid=1 and m0_rdata=0xDEADBEEF in cycle 1; m1 signals all 0.
- m0_req and m1_req held high continuously, STARVE_LIMIT=8 -> m0 granted cycles 0-7; starve_cnt reaches 8; m1_gnt=1 in cycle 8; starve_cnt=0 after; m0 regrant in cycle 9.
- m1 write burst of 4 with m1_lock=1 while m0_req=1 -> 4 consecutive m1_gnt, mem_we=1 each; m0_gnt=0 throughout; m0 granted the cycle after m1_lock falls.
- Alternating reads m0@0x4, m1@0x8, m0@0xC in consecutive cycles (m1 forced via starvation) -> rvalid strobes follow one cycle later in order m0, m1, m0 with matching data.
- rst driven low in the cycle after an m1 read grant -> m1_rvalid stays 0; starve_cnt=0; all gnt=0 while low; normal arbitration resumes after release.
- m0 write 0x1234 to 0x20 -> mem_we=1, mem_addr=0x20, mem_wdata=0x1234 for one cycle; no rvalid generated.
